// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared FSM states, op codes and round-robin helper for mem_arbiter
// Contents: state_t (IDLE/ACCESS/DONE), OP_RD/OP_WR, rr_pick()
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;
    // First active index searching from last+1 modulo n; descending scan so the nearest one wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last, input int n);
        logic [1:0] j;
        rr_pick = last;
        for (int k = n; k >= 1; k--) begin
            j = 2'((int'(last) + k) % n);
            if (req[j]) rr_pick = j;
        end
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and main_memory signals of mem_arbiter
// Requester side: req_rd, req_wr, req_addr, req_wdata (packed per requester), ack, rdata
// Memory side: rd_mem, wr_mem, addr_mem, data_in, data_out, ready_mem; status: prot_err
// slave = arbiter view, master = environment (requesters + memory) view
interface mem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int AWIDTH  = 9,
    parameter int DWIDTH  = 32
);
    logic [NUM_REQ-1:0]        req_rd;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*AWIDTH-1:0] req_addr;
    logic [NUM_REQ*DWIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]        ack;
    logic [DWIDTH-1:0]         rdata;
    logic                      rd_mem;
    logic                      wr_mem;
    logic [AWIDTH-1:0]         addr_mem;
    logic [DWIDTH-1:0]         data_in;
    logic [DWIDTH-1:0]         data_out;
    logic                      ready_mem;
    logic                      prot_err;
    modport slave (
        input  req_rd, req_wr, req_addr, req_wdata, data_out, ready_mem,
        output ack, rdata, rd_mem, wr_mem, addr_mem, data_in, prot_err
    );
    modport master (
        output req_rd, req_wr, req_addr, req_wdata, data_out, ready_mem,
        input  ack, rdata, rd_mem, wr_mem, addr_mem, data_in, prot_err
    );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selection among active requesters
// Ports: req (active vector), last (previous winner) -> any (some request), idx (winner)
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IW      = (NUM_REQ > 2) ? 2 : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic               any,
    output logic [IW-1:0]      idx
);
    assign any = |req;
    assign idx = IW'(rr_pick(4'(req), 2'(last), NUM_REQ));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of single-word requests onto one main_memory port
// Ports: clk, reset (async, active-high), bus (mem_arbiter_if.slave: requester handshake + memory port)
// Optional MEM_ARB_PROT_CHK_EN: sticky prot_err checker; otherwise prot_err is tied low.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int AWIDTH  = 9,
    parameter int DWIDTH  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 2) ? 2 : 1;
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t        state, state_nx;
    logic [IW-1:0] idx, last, pick;
    logic [CW-1:0] cnt;
    logic          op, any_req, grant, finish;

    rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr_picker (
        .req  (bus.req_rd | bus.req_wr),
        .last (last),
        .any  (any_req),
        .idx  (pick)
    );

    always_comb begin
        grant    = state == IDLE && any_req && bus.ready_mem;
        finish   = state == ACCESS && cnt == CW'(MEM_LAT - 1);
        state_nx = grant ? ACCESS : finish ? DONE : (state == ACCESS ? ACCESS : IDLE);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;

    // Write wins when a requester raises both strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ack      <= '0;
            bus.rd_mem   <= 1'b0;
            bus.wr_mem   <= 1'b0;
            bus.addr_mem <= '0;
            bus.data_in  <= '0;
            bus.rdata    <= '0;
            cnt          <= '0;
            idx          <= '0;
            op           <= OP_RD;
            last         <= IW'(NUM_REQ - 1);
        end else begin
            bus.ack <= '0;
            if (grant) begin
                idx          <= pick;
                last         <= pick;
                cnt          <= '0;
                op           <= bus.req_wr[pick] ? OP_WR : OP_RD;
                bus.wr_mem   <= bus.req_wr[pick];
                bus.rd_mem   <= !bus.req_wr[pick];
                bus.addr_mem <= bus.req_addr[pick*AWIDTH +: AWIDTH];
                bus.data_in  <= bus.req_wdata[pick*DWIDTH +: DWIDTH];
            end else if (finish) begin
                bus.rd_mem <= 1'b0;
                bus.wr_mem <= 1'b0;
                bus.ack    <= NUM_REQ'(1) << idx;
                if (op == OP_RD) bus.rdata <= bus.data_out;
            end else if (state == ACCESS) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef MEM_ARB_PROT_CHK_EN
    logic [NUM_REQ-1:0] ack_d1, ack_d2;
    // ack_d2 marks the cycle two after ack, by which the requester must have dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_d1       <= '0;
            ack_d2       <= '0;
            bus.prot_err <= 1'b0;
        end else begin
            ack_d1 <= bus.ack;
            ack_d2 <= ack_d1;
            if (|(bus.req_rd & bus.req_wr)
                || (state == ACCESS && !(bus.req_rd[idx] || bus.req_wr[idx]))
                || (state == ACCESS && bus.req_addr[idx*AWIDTH +: AWIDTH] != bus.addr_mem)
                || |(ack_d2 & (bus.req_rd | bus.req_wr)))
                bus.prot_err <= 1'b1;
        end
    end
`else
    assign bus.prot_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (MEM_LAT=2 and MEM_LAT=1 instances)
module tb_mem_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;
`ifdef MEM_ARB_PROT_CHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.NUM_REQ(2), .AWIDTH(AW), .DWIDTH(DW)) bus0 ();
    mem_arbiter_if #(.NUM_REQ(2), .AWIDTH(AW), .DWIDTH(DW)) bus1 ();

    mem_arbiter #(.NUM_REQ(2), .AWIDTH(AW), .DWIDTH(DW), .MEM_LAT(2)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );
    mem_arbiter #(.NUM_REQ(2), .AWIDTH(AW), .DWIDTH(DW), .MEM_LAT(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    logic [DW-1:0] mem0 [512];
    logic [DW-1:0] mem1 [512];
    always @(posedge clk) if (bus0.wr_mem) mem0[bus0.addr_mem] <= bus0.data_in;
    always @(posedge clk) if (bus1.wr_mem) mem1[bus1.addr_mem] <= bus1.data_in;
    assign bus0.data_out = mem0[bus0.addr_mem];
    assign bus1.data_out = mem1[bus1.addr_mem];

    logic [DW-1:0] ref_mem [512];
    bit            ref_ok  [512];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus0.req_rd = '0; bus0.req_wr = '0; bus0.req_addr = '0; bus0.req_wdata = '0; bus0.ready_mem = 1'b1;
        bus1.req_rd = '0; bus1.req_wr = '0; bus1.req_addr = '0; bus1.req_wdata = '0; bus1.ready_mem = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One transaction from IDLE; returns relative ack cycle, absolute ack cycle, strobe counts, ack vector, rdata.
    task automatic txn0(input int r, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int ac, output int at, output int nrd, output int nwr,
                        output logic [1:0] av, output logic [DW-1:0] q);
        bus0.req_addr[r*AW +: AW] = a;
        bus0.req_wdata[r*DW +: DW] = d;
        bus0.req_rd[r] = rd;
        bus0.req_wr[r] = wr;
        ac = -1; at = -1; nrd = 0; nwr = 0; av = '0; q = '0;
        for (int c = 1; c <= 12 && ac < 0; c++) begin
            tick();
            nrd += int'(bus0.rd_mem);
            nwr += int'(bus0.wr_mem);
            if (bus0.ack != 0) begin ac = c; at = cyc; av = bus0.ack; q = bus0.rdata; end
        end
        bus0.req_rd[r] = 1'b0;
        bus0.req_wr[r] = 1'b0;
        tick();
    endtask

    task automatic txn1(input int r, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int ac, output int at, output int nrd, output int nwr,
                        output logic [1:0] av, output logic [DW-1:0] q);
        bus1.req_addr[r*AW +: AW] = a;
        bus1.req_wdata[r*DW +: DW] = d;
        bus1.req_rd[r] = rd;
        bus1.req_wr[r] = wr;
        ac = -1; at = -1; nrd = 0; nwr = 0; av = '0; q = '0;
        for (int c = 1; c <= 12 && ac < 0; c++) begin
            tick();
            nrd += int'(bus1.rd_mem);
            nwr += int'(bus1.wr_mem);
            if (bus1.ack != 0) begin ac = c; at = cyc; av = bus1.ack; q = bus1.rdata; end
        end
        bus1.req_rd[r] = 1'b0;
        bus1.req_wr[r] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus0.ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", bus0.ack); end
        checks++; if (bus0.rd_mem !== 1'b0) begin errors++; $display("FAIL reset_rd_mem: got %b want 0", bus0.rd_mem); end
        checks++; if (bus0.wr_mem !== 1'b0) begin errors++; $display("FAIL reset_wr_mem: got %b want 0", bus0.wr_mem); end
        checks++; if (bus0.addr_mem !== 9'h000) begin errors++; $display("FAIL reset_addr_mem: got %h want 000", bus0.addr_mem); end
        checks++; if (bus0.data_in !== 32'h0) begin errors++; $display("FAIL reset_data_in: got %h want 0", bus0.data_in); end
        checks++; if (bus0.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus0.rdata); end
        checks++; if (bus0.prot_err !== 1'b0) begin errors++; $display("FAIL reset_prot_err: got %b want 0", bus0.prot_err); end
        checks++; if (bus1.wr_mem !== 1'b0) begin errors++; $display("FAIL reset_wr_mem1: got %b want 0", bus1.wr_mem); end
    endtask

    task automatic test_write_read();
        int ac, at, nrd, nwr;
        logic [1:0] av;
        logic [DW-1:0] q;
        do_reset();
        txn0(0, 1'b0, 1'b1, 9'h005, 32'hDEADBEEF, ac, at, nrd, nwr, av, q);
        checks++; if (nwr != 2) begin errors++; $display("FAIL wr_strobe_len: got %0d want 2", nwr); end
        checks++; if (nrd != 0) begin errors++; $display("FAIL wr_no_rd: got %0d want 0", nrd); end
        checks++; if (ac != 3) begin errors++; $display("FAIL wr_ack_cycle: got %0d want 3", ac); end
        checks++; if (av !== 2'b01) begin errors++; $display("FAIL wr_ack_vec: got %b want 01", av); end
        txn0(0, 1'b1, 1'b0, 9'h005, 32'h0, ac, at, nrd, nwr, av, q);
        checks++; if (nrd != 2) begin errors++; $display("FAIL rd_strobe_len: got %0d want 2", nrd); end
        checks++; if (ac != 3) begin errors++; $display("FAIL rd_ack_cycle: got %0d want 3", ac); end
        checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", q); end
    endtask

    task automatic test_round_robin();
        int n, prev, exp_last, e;
        do_reset();
        bus0.req_addr = {9'h011, 9'h010};
        bus0.req_rd = 2'b11;
        n = 0; prev = -1; exp_last = 1;
        for (int c = 1; c <= 24 && n < 4; c++) begin
            tick();
            if (bus0.ack != 0) begin
                e = (exp_last + 1) % 2;
                checks++; if (bus0.ack !== 2'(1 << e)) begin errors++; $display("FAIL rr_order[%0d]: got %b want %b", n, bus0.ack, 2'(1 << e)); end
                checks++;
                if (prev >= 0 && c - prev != 4) begin errors++; $display("FAIL rr_span[%0d]: got %0d want 4", n, c - prev); end
                else if (prev < 0 && c != 3) begin errors++; $display("FAIL rr_first: got %0d want 3", c); end
                prev = c; exp_last = e; n++;
            end
        end
        checks++; if (n != 4) begin errors++; $display("FAIL rr_count: got %0d want 4", n); end
        bus0.req_rd = 2'b00;
        tick();
    endtask

    task automatic test_rd_wr_conflict();
        int ac, at, nrd, nwr;
        logic [1:0] av;
        logic [DW-1:0] q;
        do_reset();
        txn0(1, 1'b1, 1'b1, 9'h020, 32'h1, ac, at, nrd, nwr, av, q);
        checks++; if (nwr != 2 || nrd != 0) begin errors++; $display("FAIL conflict_op: got wr=%0d rd=%0d want wr=2 rd=0", nwr, nrd); end
        checks++; if (av !== 2'b10) begin errors++; $display("FAIL conflict_ack: got %b want 10", av); end
        checks++; if (bus0.prot_err !== CHK) begin errors++; $display("FAIL conflict_prot_err: got %b want %b", bus0.prot_err, CHK); end
        txn0(0, 1'b1, 1'b0, 9'h020, 32'h0, ac, at, nrd, nwr, av, q);
        checks++; if (q !== 32'h1) begin errors++; $display("FAIL conflict_readback: got %h want 1", q); end
    endtask

    task automatic test_reset_mid_access();
        int got;
        logic [1:0] av;
        do_reset();
        bus0.req_addr[0 +: AW] = 9'h005;
        bus0.req_rd = 2'b01;
        tick();
        checks++; if (bus0.rd_mem !== 1'b1) begin errors++; $display("FAIL rst_pre_strobe: got %b want 1", bus0.rd_mem); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus0.rd_mem !== 1'b0) begin errors++; $display("FAIL rst_async_drop: got %b want 0", bus0.rd_mem); end
        bus0.req_addr[AW +: AW] = 9'h006;
        bus0.req_rd = 2'b11;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (bus0.ack !== 2'b00) begin errors++; $display("FAIL rst_no_ack: got %b want 00", bus0.ack); end
        end
        reset = 1'b0;
        got = -1; av = '0;
        for (int c = 1; c <= 12 && got < 0; c++) begin
            tick();
            if (bus0.ack != 0) begin got = c; av = bus0.ack; end
        end
        checks++; if (got != 3) begin errors++; $display("FAIL rst_restart_cycle: got %0d want 3", got); end
        checks++; if (av !== 2'b01) begin errors++; $display("FAIL rst_first_winner: got %b want 01", av); end
        bus0.req_rd = 2'b00;
        tick();
    endtask

    task automatic test_addr_change();
        int ac, at, nrd, nwr, got, bad;
        logic [1:0] av;
        logic [DW-1:0] q;
        do_reset();
        txn0(1, 1'b0, 1'b1, 9'h031, 32'h1111_1111, ac, at, nrd, nwr, av, q);
        checks++; if (bus0.prot_err !== 1'b0) begin errors++; $display("FAIL clean_prot_err: got %b want 0", bus0.prot_err); end
        bus0.req_addr[0 +: AW] = 9'h030;
        bus0.req_wdata[0 +: DW] = 32'hA5A5_0030;
        bus0.req_wr = 2'b01;
        got = -1; bad = 0;
        for (int c = 1; c <= 12 && got < 0; c++) begin
            tick();
            if (c == 1) begin bus0.req_addr[0 +: AW] = 9'h031; bus0.req_wdata[0 +: DW] = 32'hBAD0_0031; end
            if (bus0.wr_mem && (bus0.addr_mem !== 9'h030 || bus0.data_in !== 32'hA5A5_0030)) bad++;
            if (bus0.ack != 0) got = c;
        end
        bus0.req_wr = 2'b00;
        tick();
        checks++; if (got != 3) begin errors++; $display("FAIL addrchg_ack: got %0d want 3", got); end
        checks++; if (bad != 0) begin errors++; $display("FAIL addrchg_stable: got %0d unstable cycles want 0", bad); end
        checks++; if (bus0.prot_err !== CHK) begin errors++; $display("FAIL addrchg_prot_err: got %b want %b", bus0.prot_err, CHK); end
        txn0(0, 1'b1, 1'b0, 9'h030, 32'h0, ac, at, nrd, nwr, av, q);
        checks++; if (q !== 32'hA5A5_0030) begin errors++; $display("FAIL addrchg_030: got %h want a5a50030", q); end
        txn0(0, 1'b1, 1'b0, 9'h031, 32'h0, ac, at, nrd, nwr, av, q);
        checks++; if (q !== 32'h1111_1111) begin errors++; $display("FAIL addrchg_031: got %h want 11111111", q); end
    endtask

    task automatic test_back_to_back();
        int ac, at1, at2, nrd, nwr;
        logic [1:0] av;
        logic [DW-1:0] q;
        do_reset();
        txn1(0, 1'b0, 1'b1, 9'h1FF, 32'hCAFE_01FF, ac, at1, nrd, nwr, av, q);
        checks++; if (nwr != 1) begin errors++; $display("FAIL b2b_wr1_len: got %0d want 1", nwr); end
        checks++; if (ac != 2) begin errors++; $display("FAIL b2b_ack1_cycle: got %0d want 2", ac); end
        txn1(0, 1'b0, 1'b1, 9'h000, 32'h0BAD_F00D, ac, at2, nrd, nwr, av, q);
        checks++; if (nwr != 1) begin errors++; $display("FAIL b2b_wr2_len: got %0d want 1", nwr); end
        checks++; if (at2 - at1 != 3) begin errors++; $display("FAIL b2b_ack_spacing: got %0d want 3", at2 - at1); end
        txn1(0, 1'b1, 1'b0, 9'h1FF, 32'h0, ac, at1, nrd, nwr, av, q);
        checks++; if (q !== 32'hCAFE_01FF) begin errors++; $display("FAIL b2b_read_1ff: got %h want cafe01ff", q); end
        txn1(0, 1'b1, 1'b0, 9'h000, 32'h0, ac, at1, nrd, nwr, av, q);
        checks++; if (q !== 32'h0BAD_F00D) begin errors++; $display("FAIL b2b_read_000: got %h want 0badf00d", q); end
    endtask

    task automatic test_random();
        bit act [2];
        bit op_w [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] wd [2];
        int last, exp, got;
        do_reset();
        act[0] = 0; act[1] = 0; last = 1;
        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < 2; r++) begin
                if (!act[r] && ($urandom_range(0, 1) == 1 || (r == 1 && !act[0]))) begin
                    act[r] = 1;
                    op_w[r] = 1'($urandom_range(0, 1));
                    ad[r] = 9'h040 + 9'($urandom_range(0, 3));
                    wd[r] = $urandom;
                    bus0.req_addr[r*AW +: AW] = ad[r];
                    bus0.req_wdata[r*DW +: DW] = wd[r];
                    bus0.req_wr[r] = op_w[r];
                    bus0.req_rd[r] = !op_w[r];
                end
            end
            exp = act[(last + 1) % 2] ? (last + 1) % 2 : (last + 2) % 2;
            got = -1;
            for (int c = 0; c < 40 && got < 0; c++) begin
                bus0.ready_mem = ($urandom_range(0, 3) != 0);
                tick();
                if (bus0.ack != 0) got = c;
            end
            bus0.ready_mem = 1'b1;
            checks++;
            if (got < 0 || bus0.ack !== 2'(1 << exp)) begin
                errors++; $display("FAIL rand_grant[%0d]: got %b want %b", t, bus0.ack, 2'(1 << exp));
            end
            if (!op_w[exp] && ref_ok[ad[exp]]) begin
                checks++;
                if (bus0.rdata !== ref_mem[ad[exp]]) begin
                    errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", t, bus0.rdata, ref_mem[ad[exp]]);
                end
            end
            if (op_w[exp]) begin ref_mem[ad[exp]] = wd[exp]; ref_ok[ad[exp]] = 1; end
            last = exp;
            act[exp] = 0;
            bus0.req_rd[exp] = 1'b0;
            bus0.req_wr[exp] = 1'b0;
        end
        bus0.req_rd = 2'b00;
        bus0.req_wr = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_rd_wr_conflict();
        test_reset_mid_access();
        test_addr_change();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
